sdram_rw_arbiter_rr: RTL and testbench
======================================

Name: sdram_rw_arbiter_rr

Overview:
- Parametrised N-read / M-write arbiter in front of the four-word-burst SDRAM controller core.
- Serves independent display, draw and page-fill requesters, one burst at a time.
- Default policy is fair round-robin across all ports.
- A restricted mode, driven by a global flag such as ext-sync-lost, limits service to a masked subset of ports.
- The SDRAM core sits outside this block; the block drives only the core's request/done interface.

Parameters:
NUM_RD, 2, number of read ports (1..8)
NUM_WR, 3, number of write ports (1..8)
ADDR_W, 24, address width (bank+row+column)
DATA_W, 16, SDRAM word width
BURST, 4, words per transaction (1..8)
TIMEOUT_CYC, 1023, watchdog limit in cycles; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock (SDRAM clock domain)
rst  in  1  synchronous, active-high reset
en  in  1  arbiter enable
iRestrict  in  1  restricted mode; only masked ports are eligible
iRestrict_Mask  in  NUM_RD+NUM_WR  eligibility mask in restricted mode; bit k = combined port k
iRd_Req  in  NUM_RD  read request per port, level
iRd_Addr  in  NUM_RD*ADDR_W  read address per port
oRd_Done  out  NUM_RD  one-cycle read-done pulse
oRd_Data  out  NUM_RD*BURST*DATA_W  read burst per port; holds until that port's next read completes
iWr_Req  in  NUM_WR  write request per port, level
iWr_Addr  in  NUM_WR*ADDR_W  write address per port
iWr_Data  in  NUM_WR*BURST*DATA_W  write burst per port
oWr_Done  out  NUM_WR  one-cycle write-done pulse
oMem_Req  out  2  to the SDRAM core: [1] write, [0] read; never 2'b11
oMem_Addr  out  ADDR_W  to the SDRAM core
oMem_WrData  out  BURST*DATA_W  to the SDRAM core; word 0 in the LSBs
iMem_RdData  in  BURST*DATA_W  from the SDRAM core
iMem_Done  in  2  from the SDRAM core: [1] write done, [0] read done
oTimeout  out  1  watchdog abort pulse; tied 0 when the macro is absent

Behaviour:
- Combined port index k:
  - reads occupy k = 0..NUM_RD-1;
  - writes occupy k = NUM_RD..NUM_RD+NUM_WR-1.
- Reset values: all outputs 0, rr_ptr = 0, state IDLE. Reset applies mid-transaction as well: oMem_Req drops the cycle after rst.
- States are IDLE, ISSUE, PULSE.
- IDLE:
  - eligible = {iWr_Req, iRd_Req} & (iRestrict ? iRestrict_Mask : all-ones).
  - If en=1 and eligible is non-zero, grant the first set bit searching from rr_ptr upward with wrap.
  - On that edge, register g, oMem_Req (2'b01 for a read, 2'b10 for a write), oMem_Addr and oMem_WrData from port g. Next state ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Hold oMem_Req, oMem_Addr and oMem_WrData stable.
  - When the iMem_Done bit matching the request type is 1: oMem_Req <= 0. For a read, capture iMem_RdData into port g's oRd_Data. Set the done bit of port g. Next state PULSE.
  - Ignore the non-matching iMem_Done bit.
- PULSE:
  - Clear the done bit; rr_ptr <= (g+1) mod (NUM_RD+NUM_WR); next state IDLE.
  - The done pulse is exactly one cycle and is high only while in PULSE.
- Requester contract: drop the request on the edge where done is seen. IDLE samples one cycle later, so a dropped request is not served again. A request still held is re-served only after every other eligible port has had a turn.
- Latency, idle arbiter with core done arriving D cycles after oMem_Req rises:
  - req seen at edge 0;
  - oMem_Req high from edge 1;
  - done pulse from edge 1+D+1;
  - next grant possible at edge 1+D+3.
- en=0:
  - no new grant;
  - a transaction already in ISSUE runs to completion, including its done pulse;
  - the block then stays in IDLE.
- Changes to iRestrict or iRestrict_Mask affect only the next arbitration, never the transaction in flight.
- Request/address/data changes during ISSUE are ignored; the values are latched at grant.

Optional Feature:
ARB_TIMEOUT_EN:
- When defined, a counter runs in ISSUE. If it reaches TIMEOUT_CYC with no matching iMem_Done:
  - oMem_Req <= 0;
  - oTimeout pulses one cycle;
  - port g gets its done pulse, with oRd_Data unchanged for a read;
  - rr_ptr advances as normal.
- The counter clears on entry to ISSUE.
- When not defined, ISSUE waits indefinitely and oTimeout is constant 0.

Test Plan:
- Single read, port 0, addr 24'h000100; core returns 64'h4444_3333_2222_1111 with D=5 -> oMem_Req=01 at edge 1; oRd_Done[0] is one cycle at edge 7; oRd_Data port 0 = that value.
- All 5 ports requesting continuously (default params) -> grant order 0,1,2,3,4,0; each done exactly once per round.
- iRestrict=1, mask 5'b00101, all requesting -> only ports 0 and 2 are served, alternating; ports 1, 3, 4 never get a done.
- en dropped 2 cycles into ISSUE on a write to port 3 (k=3), D=6 -> write completes, oWr_Done[1] pulses, then no further oMem_Req while en=0.
- rst asserted during ISSUE -> next cycle oMem_Req=00, all done bits 0, rr_ptr=0; first grant after release goes to the lowest eligible k.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=15, core never answers a read on port 1 -> oTimeout plus oRd_Done[1] pulse; oRd_Data port 1 unchanged; next port served.

Source files
------------

// File: rtl/sdram_rw_arbiter_rr.sv
// sdram_rw_arbiter_rr: round-robin arbiter that lets NUM_RD read and NUM_WR write requesters share one burst-oriented SDRAM core.
// Latency: a request seen at edge 0 drives oMem_Req from edge 1. The port's done pulse follows one cycle after the core's done. The next grant is possible two cycles after that.
// Backpressure: requests are levels held until done. One burst is in flight at a time, and ISSUE waits for the core (or for the watchdog when ARB_TIMEOUT_EN is defined).
//
// Ports:
//   clk, rst (sync, active-high), en (grant enable), iRestrict/iRestrict_Mask (eligibility filter)
//   iRd_Req/iRd_Addr -> oRd_Done/oRd_Data    : read requesters, combined index k = 0..NUM_RD-1
//   iWr_Req/iWr_Addr/iWr_Data -> oWr_Done    : write requesters, combined index k = NUM_RD..NUM_RD+NUM_WR-1
//   oMem_Req/oMem_Addr/oMem_WrData, iMem_RdData/iMem_Done : SDRAM core request/done interface
//   oTimeout : watchdog abort pulse, present only with the ARB_TIMEOUT_EN macro (otherwise tied 0)
module sdram_rw_arbiter_rr #(
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 3,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int BURST       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           iRestrict,
  input  logic [NUM_RD+NUM_WR-1:0]       iRestrict_Mask,
  input  logic [NUM_RD-1:0]              iRd_Req,
  input  logic [NUM_RD*ADDR_W-1:0]       iRd_Addr,
  output logic [NUM_RD-1:0]              oRd_Done,
  output logic [NUM_RD*BURST*DATA_W-1:0] oRd_Data,
  input  logic [NUM_WR-1:0]              iWr_Req,
  input  logic [NUM_WR*ADDR_W-1:0]       iWr_Addr,
  input  logic [NUM_WR*BURST*DATA_W-1:0] iWr_Data,
  output logic [NUM_WR-1:0]              oWr_Done,
  output logic [1:0]                     oMem_Req,
  output logic [ADDR_W-1:0]              oMem_Addr,
  output logic [BURST*DATA_W-1:0]        oMem_WrData,
  input  logic [BURST*DATA_W-1:0]        iMem_RdData,
  input  logic [1:0]                     iMem_Done,
  output logic                           oTimeout
);

  localparam int NP    = NUM_RD + NUM_WR;
  localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;
  localparam int BW    = BURST * DATA_W;
  localparam logic [IDX_W:0] NP_W = (IDX_W+1)'(NP);

  typedef enum logic [1:0] {IDLE, ISSUE, PULSE} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         g_q, g_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [BW-1:0]            mem_wrdata_q, mem_wrdata_d;
  logic [NUM_RD*BW-1:0]     rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_done_q, rd_done_d;
  logic [NUM_WR-1:0]        wr_done_q, wr_done_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick. The eligible vector is doubled and rotated right by
  // rr_ptr, so the lowest set bit is the first requester at or after rr_ptr.
  // The offset is then mapped back to the combined index, modulo NP.
  // ---------------------------------------------------------------------------
  logic [NP-1:0]    eligible;
  logic [2*NP-1:0]  rot;
  logic             grant_vld;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] grant_idx;

  always_comb begin
    eligible  = {iWr_Req, iRd_Req} & (iRestrict ? iRestrict_Mask : {NP{1'b1}});
    rot       = {eligible, eligible} >> rr_ptr_q;
    grant_vld = 1'b0;
    off       = '0;
    // Descending scan: the last hit, which is the lowest offset, wins.
    for (int i = NP - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_vld = 1'b1;
        off       = IDX_W'(i);
      end
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (sum >= NP_W) begin
      sum = sum - NP_W;
    end
    grant_idx = sum[IDX_W-1:0];
  end

  // Address and write data of the port that would be granted this cycle.
  logic             sel_is_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [BW-1:0]    sel_wdata;

  always_comb begin
    sel_is_wr = (grant_idx >= IDX_W'(NUM_RD));
    sel_addr  = '0;
    sel_wdata = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (grant_idx == IDX_W'(r)) begin
        sel_addr = iRd_Addr[r*ADDR_W +: ADDR_W];
      end
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (grant_idx == IDX_W'(NUM_RD + w)) begin
        sel_addr  = iWr_Addr[w*ADDR_W +: ADDR_W];
        sel_wdata = iWr_Data[w*BW +: BW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion detection. Only the iMem_Done bit that matches the outstanding
  // request type counts. The watchdog abort ends ISSUE the same way, but it
  // leaves the read data untouched.
  // ---------------------------------------------------------------------------
  logic done_hit;
  logic abort;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    done_hit = (state_q == ISSUE) && ((mem_req_q & iMem_Done) != 2'b00);
`ifdef ARB_TIMEOUT_EN
    // cnt_q counts completed ISSUE cycles. The abort fires on the
    // TIMEOUT_CYC-th cycle spent in ISSUE without a matching done.
    abort = (state_q == ISSUE) && !done_hit && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    abort = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    rr_ptr_d     = rr_ptr_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wrdata_d = mem_wrdata_q;
    rd_data_d    = rd_data_q;
    rd_done_d    = rd_done_q;
    wr_done_d    = wr_done_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    tmo_d        = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (en && grant_vld) begin
          g_d          = grant_idx;
          mem_req_d    = sel_is_wr ? 2'b10 : 2'b01;
          mem_addr_d   = sel_addr;
          mem_wrdata_d = sel_wdata;
          state_d      = ISSUE;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end

      ISSUE: begin
        if (done_hit || abort) begin
          mem_req_d = 2'b00;
          for (int r = 0; r < NUM_RD; r++) begin
            if (g_q == IDX_W'(r)) begin
              rd_done_d[r] = 1'b1;
              if (done_hit) begin
                rd_data_d[r*BW +: BW] = iMem_RdData;
              end
            end
          end
          for (int w = 0; w < NUM_WR; w++) begin
            if (g_q == IDX_W'(NUM_RD + w)) begin
              wr_done_d[w] = 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          tmo_d = abort;
`endif
          state_d = PULSE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      PULSE: begin
        rd_done_d = '0;
        wr_done_d = '0;
        rr_ptr_d  = (g_q == IDX_W'(NP - 1)) ? '0 : g_q + IDX_W'(1);
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      g_q          <= '0;
      rr_ptr_q     <= '0;
      mem_req_q    <= 2'b00;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      rd_data_q    <= '0;
      rd_done_q    <= '0;
      wr_done_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      rr_ptr_q     <= rr_ptr_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrdata_q <= mem_wrdata_d;
      rd_data_q    <= rd_data_d;
      rd_done_q    <= rd_done_d;
      wr_done_q    <= wr_done_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign oMem_Req    = mem_req_q;
  assign oMem_Addr   = mem_addr_q;
  assign oMem_WrData = mem_wrdata_q;
  assign oRd_Data    = rd_data_q;
  assign oRd_Done    = rd_done_q;
  assign oWr_Done    = wr_done_q;

`ifdef ARB_TIMEOUT_EN
  assign oTimeout = tmo_q;
`else
  // Without the watchdog the limit has no effect, so the output is constant low.
  assign oTimeout = 1'b0 & (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_sdram_rw_arbiter_rr.sv
// Directed testbench for sdram_rw_arbiter_rr with the default port counts (2 read, 3 write).
// DUT outputs are sampled on the falling edge, and inputs are driven there as well.
module tb_sdram_rw_arbiter_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         iRestrict;
  logic [4:0]   iRestrict_Mask;
  logic [1:0]   iRd_Req;
  logic [47:0]  iRd_Addr;
  logic [1:0]   oRd_Done;
  logic [127:0] oRd_Data;
  logic [2:0]   iWr_Req;
  logic [71:0]  iWr_Addr;
  logic [191:0] iWr_Data;
  logic [2:0]   oWr_Done;
  logic [1:0]   oMem_Req;
  logic [23:0]  oMem_Addr;
  logic [63:0]  oMem_WrData;
  logic [63:0]  iMem_RdData;
  logic [1:0]   iMem_Done;
  logic         oTimeout;

  int total = 0;
  int bad   = 0;

  logic [23:0] addr_k [5];
  logic [63:0] wdat_k [5];
  logic [63:0] exp_rd [2];

  always #5 clk = ~clk;

  sdram_rw_arbiter_rr #(
    .NUM_RD(2), .NUM_WR(3), .ADDR_W(24), .DATA_W(16), .BURST(4), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .iRestrict(iRestrict), .iRestrict_Mask(iRestrict_Mask),
    .iRd_Req(iRd_Req), .iRd_Addr(iRd_Addr), .oRd_Done(oRd_Done), .oRd_Data(oRd_Data),
    .iWr_Req(iWr_Req), .iWr_Addr(iWr_Addr), .iWr_Data(iWr_Data), .oWr_Done(oWr_Done),
    .oMem_Req(oMem_Req), .oMem_Addr(oMem_Addr), .oMem_WrData(oMem_WrData),
    .iMem_RdData(iMem_RdData), .iMem_Done(iMem_Done), .oTimeout(oTimeout)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge where the grant of port k should be visible.
  // The core model answers d cycles after oMem_Req rises. In the first of those
  // cycles it pulses the wrong done bit, which the arbiter must ignore. After
  // the done pulse has been checked, the requests are replaced by nxt_req.
  // The task returns at the falling edge where the next grant would be visible.
  task automatic txn(input int k, input int d, input logic [63:0] rdat,
                     input logic [4:0] nxt_req, input logic nxt_restrict, input int en_drop);
    logic [1:0] exp_req;
    logic [4:0] oh;
    exp_req = (k < 2) ? 2'b01 : 2'b10;
    oh      = 5'b00001 << k;
    chk($sformatf("grant_k%0d_req", k), oMem_Req, exp_req);
    chk($sformatf("grant_k%0d_addr", k), oMem_Addr, addr_k[k]);
    if (k >= 2) chk($sformatf("grant_k%0d_wdata", k), oMem_WrData, wdat_k[k]);
    for (int i = 0; i < d; i++) begin
      iMem_Done = (i == 0) ? {exp_req[0], exp_req[1]} : 2'b00;
      if (i == en_drop) en = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("hold_k%0d_req", k), oMem_Req, exp_req);
    chk($sformatf("hold_k%0d_nodone", k), {oWr_Done, oRd_Done}, 5'b0);
    iMem_Done   = exp_req;
    iMem_RdData = rdat;
    @(negedge clk);
    iMem_Done   = 2'b00;
    iMem_RdData = 64'hFFFF_0000_FFFF_0000;
    if (k < 2) exp_rd[k] = rdat;
    chk($sformatf("done_k%0d_pulse", k), {oWr_Done, oRd_Done}, oh);
    chk($sformatf("done_k%0d_rddata", k), oRd_Data, {exp_rd[1], exp_rd[0]});
    chk($sformatf("done_k%0d_reqlow", k), oMem_Req, 2'b00);
    chk($sformatf("done_k%0d_notmo", k), oTimeout, 1'b0);
    {iWr_Req, iRd_Req} = nxt_req;
    iRestrict = nxt_restrict;
    @(negedge clk);
    chk($sformatf("post_k%0d_doneclr", k), {oWr_Done, oRd_Done}, 5'b0);
    chk($sformatf("post_k%0d_reqlow", k), oMem_Req, 2'b00);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    addr_k[0] = 24'h000100; addr_k[1] = 24'hA00001;
    addr_k[2] = 24'hB00002; addr_k[3] = 24'hB00003; addr_k[4] = 24'hB00004;
    wdat_k[0] = '0; wdat_k[1] = '0;
    wdat_k[2] = 64'h2222_2020_0202_2200;
    wdat_k[3] = 64'h3333_3030_0303_3300;
    wdat_k[4] = 64'h4444_4040_0404_4400;
    exp_rd[0] = '0; exp_rd[1] = '0;

    rst = 1'b1; en = 1'b1; iRestrict = 1'b0; iRestrict_Mask = 5'b0;
    iRd_Req = '0; iWr_Req = '0;
    iRd_Addr = {addr_k[1], addr_k[0]};
    iWr_Addr = {addr_k[4], addr_k[3], addr_k[2]};
    iWr_Data = {wdat_k[4], wdat_k[3], wdat_k[2]};
    iMem_RdData = '0; iMem_Done = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", oMem_Req, 2'b00);
    chk("rst_addr", oMem_Addr, 24'h0);
    chk("rst_wdata", oMem_WrData, 64'h0);
    chk("rst_rddata", oRd_Data, 128'h0);
    chk("rst_done", {oWr_Done, oRd_Done}, 5'b0);
    chk("rst_tmo", oTimeout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single read on port 0 with D=5. The done pulse lands on the 7th edge
    // after the request is sampled, and the request is then dropped.
    iRd_Req = 2'b01;
    @(negedge clk);
    txn(0, 5, 64'h4444_3333_2222_1111, 5'b00000, 1'b0, -1);
    chk("single_no_reserve", oMem_Req, 2'b00);

    // rr_ptr is now 1, so with every port requesting, port 1 wins.
    // Reset during ISSUE must drop the request and return rr_ptr to 0.
    {iWr_Req, iRd_Req} = 5'b11111;
    @(negedge clk);
    chk("pre_rst_grant_req", oMem_Req, 2'b01);
    chk("pre_rst_grant_addr", oMem_Addr, addr_k[1]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_rd[0] = '0;
    chk("midrst_req", oMem_Req, 2'b00);
    chk("midrst_done", {oWr_Done, oRd_Done}, 5'b0);
    chk("midrst_rddata", oRd_Data, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Full round-robin: 0,1,2,3,4. Restricted mode is switched on while port 4
    // is in flight and must not disturb it. After that only 0 and 2 alternate.
    txn(0, 2, 64'h0A0A_0B0B_0C0C_0D0D, 5'b11111, 1'b0, -1);
    txn(1, 3, 64'h1111_1212_1313_1414, 5'b11111, 1'b0, -1);
    txn(2, 2, 64'h0,                   5'b11111, 1'b0, -1);
    txn(3, 4, 64'h0,                   5'b11111, 1'b0, -1);
    iRestrict = 1'b1;
    iRestrict_Mask = 5'b00101;
    txn(4, 2, 64'h0,                   5'b11111, 1'b1, -1);
    txn(0, 3, 64'h5555_6666_7777_8888, 5'b11111, 1'b1, -1);
    txn(2, 2, 64'h0,                   5'b11111, 1'b1, -1);
    txn(0, 2, 64'h9999_AAAA_BBBB_CCCC, 5'b11111, 1'b1, -1);
    txn(2, 2, 64'h0,                   5'b01000, 1'b0, -1);

    // Write on k=3 with D=6. en drops 2 cycles into ISSUE, the write still
    // completes, and no new request follows while en stays low.
    txn(3, 6, 64'h0, 5'b01000, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("en_low_idle%0d", i), oMem_Req, 2'b00);
      @(negedge clk);
    end
    en = 1'b1;
    @(negedge clk);
    txn(3, 2, 64'h0, 5'b00000, 1'b0, -1);
    chk("end_idle", oMem_Req, 2'b00);

`ifdef ARB_TIMEOUT_EN
    // rr_ptr = 4, ports 1 and 2 request, and the core never answers the read on port 1.
    begin
      int cyc;
      {iWr_Req, iRd_Req} = 5'b00110;
      @(negedge clk);
      chk("tmo_grant_req", oMem_Req, 2'b01);
      chk("tmo_grant_addr", oMem_Addr, addr_k[1]);
      cyc = 0;
      while (oTimeout !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk("tmo_seen", oTimeout, 1'b1);
      chk("tmo_cycles", cyc, 15);
      chk("tmo_done", {oWr_Done, oRd_Done}, 5'b00010);
      chk("tmo_rddata", oRd_Data, {exp_rd[1], exp_rd[0]});
      iRd_Req = 2'b00;
      @(negedge clk);
      chk("tmo_clear", oTimeout, 1'b0);
      @(negedge clk);
      txn(2, 2, 64'h0, 5'b00000, 1'b0, -1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
